// File: rtl/seq_mul_ctrl_pkg.sv
// Shared multiplier constants: FSM state encodings and the default operand width.
package seq_mul_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mul_ctrl_register.sv
// Generic parameterized register with synchronous active-high reset to zero
// and a write enable.
module register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold the stored value unless written; reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_mul_ctrl.sv
// Sequential shift-and-add unsigned multiplier. One start accepted in IDLE
// runs exactly WIDTH CALC iterations, then a one-cycle DONE that presents
// the product, which is held until the next result is produced.
module seq_mul_ctrl
    import seq_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Count reaches WIDTH after the last iteration, so it needs room for WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t state_reg;
    state_t state_next;

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;

    logic               load;
    logic               shift;

    logic               acc_en;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] acc_q;

    logic               cnt_en;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               prod_en;

    // Iteration counter.
    register #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    // Running partial-product accumulator.
    register #(.W(2*WIDTH)) u_acc (
        .clk   (clk),
        .reset (reset),
        .en    (acc_en),
        .d     (acc_d),
        .q     (acc_q)
    );

    // Product holding register: written only on the final CALC edge with the
    // completed sum, so the output stays stable through the next operation.
    register #(.W(2*WIDTH)) u_prod (
        .clk   (clk),
        .reset (reset),
        .en    (prod_en),
        .d     (acc_d),
        .q     (product)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand shift registers: load on accepted start, shift every CALC edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (load) begin
            mcand_reg  <= (2*WIDTH)'(multiplicand);
            mplier_reg <= multiplier;
        end else if (shift) begin
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
        end
    end

    // Next-state logic and datapath write enables.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift      = 1'b0;
        acc_en     = 1'b0;
        acc_d      = '0;
        cnt_en     = 1'b0;
        cnt_d      = '0;
        prod_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                    load       = 1'b1;
                    acc_en     = 1'b1;
                    cnt_en     = 1'b1;
                end
            end
            CALC: begin
                shift  = 1'b1;
                acc_en = 1'b1;
                acc_d  = acc_q + (mplier_reg[0] ? mcand_reg : '0);
                cnt_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // No early exit: always run all WIDTH iterations.
                if (cnt_q == LAST_CNT) begin
                    state_next = DONE;
                    prod_en    = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready = (state_reg == IDLE);
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Randomized plus directed testbench for seq_mul_ctrl against a
// cycle-counting behavioural model using plain integer multiplication.
module tb_seq_mul_ctrl;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ready;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_compared;
    int n_mismatched;

    // Reference model state
    bit  m_idle;
    int  m_t;
    int  m_pend;
    int  m_prod;
    int  m_done_cnt;

    seq_mul_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (rst),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .ready        (ready),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_compared++;
        if (obs != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic cyc(input bit r, input bit s, input int av, input int bv);
        bit exp_done;
        @(negedge clk);
        rst   = r;
        start = s;
        a     = WIDTH'(av);
        b     = WIDTH'(bv);
        @(posedge clk);
        if (r) begin
            m_idle = 1'b1;
            m_prod = 0;
        end else if (m_idle) begin
            if (s) begin
                m_idle = 1'b0;
                m_t    = 0;
                m_pend = (av % (1 << WIDTH)) * (bv % (1 << WIDTH));
            end
        end else begin
            m_t++;
            if (m_t == WIDTH) m_prod = m_pend;
            if (m_t == WIDTH + 1) m_idle = 1'b1;
        end
        exp_done = !m_idle && (m_t == WIDTH);
        #1;
        chk("ready",   int'(ready),   int'(m_idle));
        chk("done",    int'(done),    int'(exp_done));
        chk("product", int'(product), m_prod);
        if (done) m_done_cnt++;
        $display("cyc r=%0b s=%0b a=%0d b=%0d | ready=%0b done=%0b product=%0d",
                 r, s, av, bv, ready, done, product);
    endtask

    // Start one multiply, then idle-drive with scrambled operands until back in IDLE.
    task automatic mul(input int av, input int bv);
        cyc(1'b0, 1'b1, av, bv);
        for (int i = 0; i < WIDTH + 1; i++) begin
            cyc(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15));
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        m_idle = 1'b1; m_t = 0; m_pend = 0; m_prod = 0; m_done_cnt = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;

        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 7, 7);           // reset beats start
        cyc(1'b0, 1'b0, 0, 0);

        mul(3, 5);                       // 15
        mul(15, 15);                     // 225, no truncation
        mul(0, 9);
        mul(9, 0);

        // 6*7 with start and A=1,B=1 held through the operation
        cyc(1'b0, 1'b1, 6, 7);
        for (int i = 0; i < WIDTH + 3; i++) cyc(1'b0, 1'b1, 1, 1);
        for (int i = 0; i < WIDTH + 2; i++) cyc(1'b0, 1'b0, 0, 0);

        // reset mid-operation of 12*13, then 2*3
        cyc(1'b0, 1'b1, 12, 13);
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);
        mul(2, 3);

        // back-to-back 5*5 then 4*4 with start held high
        m_done_cnt = 0;
        cyc(1'b0, 1'b1, 5, 5);
        for (int i = 0; i < WIDTH + 1; i++) cyc(1'b0, 1'b1, 4, 4);
        for (int i = 0; i < WIDTH + 1; i++) cyc(1'b0, 1'b1, 4, 4);
        cyc(1'b0, 1'b0, 0, 0);
        chk("b2b_done_pulses", m_done_cnt, 2);
        for (int i = 0; i < WIDTH + 2; i++) cyc(1'b0, 1'b0, 0, 0);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                $urandom_range(0, 15), $urandom_range(0, 15));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
